uart_tx_ctrl: RTL

Sequencer for the UART transmit path; it sits between the APB-side register writes and the UART frame transmitter.
- Buffers outgoing bytes in a small FIFO.
- Generates the baud tick from the system clock.
- Launches one frame at a time on the transmitter using a start/busy/done handshake.
- Reports FIFO and controller status back to the bus side.

---
 rtl/uart_tx_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: byte FIFO, baud tick generator and a frame launch FSM
// that hands one byte at a time to the frame transmitter over start/busy/done.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          tx_enable,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          tx_tick,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_sent,
  output logic                          ctrl_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  state_t                state, state_nxt;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  pop, wr_accept;

  // Baud generator; >= (not ==) so a lowered divisor ticks at once instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      tx_tick  <= 1'b0;
    end else if (!tx_enable) begin
      baud_cnt <= '0;
      tx_tick  <= 1'b0;
    end else if (baud_cnt >= baud_div) begin
      baud_cnt <= '0;
      tx_tick  <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
      tx_tick  <= 1'b0;
    end
  end

  assign fifo_full  = (fifo_count == FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign pop        = (state == IDLE) & tx_enable & tx_tick & ~fifo_empty & ~tx_busy;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign wr_accept  = wr_en & (~fifo_full | pop);
  assign overflow   = wr_en & fifo_full & ~pop;
  assign ctrl_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_data    <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end
      case ({wr_accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx_start   = 1'b0;
    frame_sent = 1'b0;
    case (state)
      IDLE:      if (pop) state_nxt = LAUNCH;
      LAUNCH: begin
        tx_start = 1'b1;
        if (tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (tx_done) begin
        frame_sent = 1'b1;
        state_nxt  = GAP;
      end
      // One full baud period of idle line before the next launch is possible.
      GAP:       if (tx_tick) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
endmodule
